// File: rtl/dmem_host_loader.sv
`default_nettype none
// ============================================================================
// Module      : dmem_host_loader
// Description : Host-side DMem initiator: load bytes, run the core, dump results.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_host_loader #(
  parameter int ADDR_W      = 8,
  parameter int LOAD_LEN    = 64,
  parameter int DUMP_BASE   = 0,
  parameter int DUMP_LEN    = 64,
  parameter int RUN_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              core_reset,
  input  logic              core_done,
  output logic              host_owns,
  output logic              dm_wen,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [7:0]        dm_wdat,
  input  logic [7:0]        dm_rdat,
  output logic              busy,
  output logic              timeout
);

  localparam int LD_W  = $clog2(LOAD_LEN + 1);
  localparam int DP_W  = $clog2(DUMP_LEN + 1);
  localparam int RUN_W = $clog2(RUN_TIMEOUT + 1);

  localparam logic [LD_W-1:0]   c_LD_LAST   = LD_W'(LOAD_LEN - 1);
  localparam logic [DP_W-1:0]   c_DP_LAST   = DP_W'(DUMP_LEN);
  localparam logic [RUN_W-1:0]  c_RUN_LAST  = RUN_W'(RUN_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] c_DUMP_BASE = ADDR_W'(DUMP_BASE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DUMP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [LD_W-1:0]   r_ld_cnt;
  logic [DP_W-1:0]   r_dp_cnt;
  logic [RUN_W-1:0]  r_run_cnt;
  logic              r_timeout;
  logic              r_out_valid;
  logic [7:0]        r_out_data;

  logic              w_xfer;
  logic              w_done;
  logic              w_expire;
  logic              w_dump_acc;

  // core_done is masked on the first RUN cycle while the core leaves reset
  assign w_xfer     = (r_state == S_LOAD) && in_valid;
  assign w_done     = (r_state == S_RUN) && (r_run_cnt != '0) && core_done;
  assign w_expire   = (r_state == S_RUN) && !w_done && (r_run_cnt == c_RUN_LAST);
  assign w_dump_acc = (r_state == S_DUMP) && r_out_valid && out_ready;

  assign core_reset = (r_state != S_RUN);
  assign host_owns  = (r_state != S_RUN);
  assign busy       = (r_state != S_IDLE);
  assign timeout    = r_timeout;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    dm_wen   = 1'b0;
    dm_addr  = '0;
    dm_wdat  = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        dm_addr  = ADDR_W'(r_ld_cnt);
        if (w_xfer) begin
          dm_wen  = 1'b1;
          dm_wdat = in_data;
          if (r_ld_cnt == c_LD_LAST) w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_done || w_expire) w_next = S_DUMP;
      end
      S_DUMP: begin
        dm_addr = c_DUMP_BASE + ADDR_W'(r_dp_cnt);
        if (w_dump_acc && (r_dp_cnt == c_DP_LAST)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_cnt    <= '0;
      r_dp_cnt    <= '0;
      r_run_cnt   <= '0;
      r_timeout   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_timeout <= 1'b0;
            r_ld_cnt  <= '0;
            r_run_cnt <= '0;
            r_dp_cnt  <= '0;
          end
        end
        S_LOAD: begin
          if (w_xfer) r_ld_cnt <= r_ld_cnt + 1'b1;
        end
        S_RUN: begin
          r_run_cnt <= r_run_cnt + 1'b1;
          if (w_expire) r_timeout <= 1'b1;
        end
        S_DUMP: begin
          // r_dp_cnt counts bytes already presented on out_data
          if (!r_out_valid) begin
            r_out_data  <= dm_rdat;
            r_out_valid <= 1'b1;
            r_dp_cnt    <= DP_W'(1);
          end else if (out_ready) begin
            if (r_dp_cnt == c_DP_LAST) begin
              r_out_valid <= 1'b0;
            end else begin
              r_out_data <= dm_rdat;
              r_dp_cnt   <= r_dp_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_host_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_host_loader
// Description : Directed bench for dmem_host_loader with a DMem and core model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_host_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       core_done = 1'b0;
  logic       in_ready, out_valid, core_reset, host_owns, dm_wen, busy, timeout;
  logic [7:0] out_data, dm_addr, dm_wdat, dm_rdat;

  logic       core_wen = 1'b0;
  logic [7:0] core_addr = 8'h00;
  logic [7:0] core_wdat = 8'h00;
  logic [7:0] mem [256];
  logic       mux_wen;
  logic [7:0] mux_addr, mux_wdat;

  int n_vec = 0;
  int n_err = 0;

  dmem_host_loader #(
    .ADDR_W(8), .LOAD_LEN(4), .DUMP_BASE(8'h10), .DUMP_LEN(3), .RUN_TIMEOUT(20)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .core_reset(core_reset), .core_done(core_done), .host_owns(host_owns),
    .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdat(dm_wdat), .dm_rdat(dm_rdat),
    .busy(busy), .timeout(timeout)
  );

  // top-level DMem mux: host port when host_owns, core port otherwise
  assign mux_wen  = host_owns ? dm_wen  : core_wen;
  assign mux_addr = host_owns ? dm_addr : core_addr;
  assign mux_wdat = host_owns ? dm_wdat : core_wdat;
  assign dm_rdat  = mem[mux_addr];

  always @(posedge clk) if (mux_wen) mem[mux_addr] <= mux_wdat;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic start_seq();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic load4(input logic [31:0] b);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = b[31-8*i -: 8];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic core_run();
    logic [23:0] ex = 24'h5A6B7C;
    for (int j = 0; j < 3; j++) begin
      core_wen = 1'b1; core_addr = 8'h10 + 8'(j); core_wdat = ex[23-8*j -: 8];
      @(negedge clk);
    end
    core_wen = 1'b0; core_done = 1'b1;
    @(negedge clk); core_done = 1'b0;
  endtask

  // entered on the first DUMP cycle; expects 5A,6B,7C at 0x10..0x12
  task automatic drain_dump(input int stall_byte, input int stall_n, input bit pulse_start);
    logic [23:0] ex = 24'h5A6B7C;
    #1;
    n_vec++;
    if ({core_reset, host_owns, busy, out_valid, dm_wen} !== 5'b11100 || dm_addr !== 8'h10) begin
      n_err++;
      $display("FAIL dump_entry: got cr/ho/busy/ov/wen=%b addr=%h want 11100 addr=10",
               {core_reset, host_owns, busy, out_valid, dm_wen}, dm_addr);
    end
    out_ready = 1'b1;
    if (pulse_start) start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); start = 1'b0;
      if (i == stall_byte) begin
        out_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          #1;
          n_vec++;
          if (out_valid !== 1'b1 || out_data !== ex[23-8*i -: 8]) begin
            n_err++;
            $display("FAIL dump_hold[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data,
                     ex[23-8*i -: 8]);
          end
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== ex[23-8*i -: 8]) begin
        n_err++;
        $display("FAIL dump_byte[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data,
                 ex[23-8*i -: 8]);
      end
    end
    @(negedge clk); #1;
    n_vec++;
    if ({out_valid, busy, core_reset, host_owns} !== 4'b0011) begin
      n_err++;
      $display("FAIL dump_exit: got ov/busy/cr/ho=%b want 0011", {out_valid, busy, core_reset, host_owns});
    end
    out_ready = 1'b0;
    @(negedge clk); #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_stays: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_data = 8'hEE;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({core_reset, host_owns, busy, timeout, in_ready, out_valid, dm_wen} !== 7'b1100000 ||
        out_data !== 8'h00 || dm_addr !== 8'h00 || dm_wdat !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: got flags=%b od=%h a=%h wd=%h want 1100000 00 00 00",
               {core_reset, host_owns, busy, timeout, in_ready, out_valid, dm_wen},
               out_data, dm_addr, dm_wdat);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || dm_wen !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ignores_valid: got busy=%b wen=%b want 0 0", busy, dm_wen);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_load();
    logic [39:0] dv = 40'hA1_B2_00_C3_D4;
    logic [4:0]  vv = 5'b11011;
    logic [7:0]  ea = 8'h00;
    start_seq();
    #1;
    n_vec++;
    if ({in_ready, busy, core_reset, timeout} !== 4'b1110) begin
      n_err++;
      $display("FAIL load_entry: got rdy/busy/cr/to=%b want 1110", {in_ready, busy, core_reset, timeout});
    end
    for (int s = 0; s < 5; s++) begin
      in_valid = vv[4-s]; in_data = dv[39-8*s -: 8];
      #1;
      n_vec++;
      if (dm_wen !== vv[4-s] || core_reset !== 1'b1 ||
          (vv[4-s] && (dm_addr !== ea || dm_wdat !== dv[39-8*s -: 8]))) begin
        n_err++;
        $display("FAIL load_slot[%0d]: got wen=%b a=%h d=%h cr=%b want wen=%b a=%h d=%h cr=1",
                 s, dm_wen, dm_addr, dm_wdat, core_reset, vv[4-s], ea, dv[39-8*s -: 8]);
      end
      if (vv[4-s]) ea = ea + 8'd1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    n_vec++;
    if ({core_reset, host_owns, in_ready, dm_wen, busy} !== 5'b00001) begin
      n_err++;
      $display("FAIL run_entry: got cr/ho/rdy/wen/busy=%b want 00001",
               {core_reset, host_owns, in_ready, dm_wen, busy});
    end
    n_vec++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== 32'hA1B2C3D4) begin
      n_err++;
      $display("FAIL load_mem: got %h want a1b2c3d4", {mem[0], mem[1], mem[2], mem[3]});
    end
  endtask

  task automatic test_run_done();
    core_run();
    drain_dump(3, 0, 1'b0);
  endtask

  task automatic test_stall();
    start_seq();
    load4(32'h01020304);
    core_run();
    drain_dump(1, 3, 1'b0);
  endtask

  task automatic test_timeout();
    int cnt = 0;
    start_seq();
    load4(32'h11223344);
    #1;
    while (core_reset === 1'b0 && cnt < 100) begin
      cnt++;
      @(negedge clk); #1;
    end
    n_vec++;
    if (cnt !== 20 || timeout !== 1'b1) begin
      n_err++;
      $display("FAIL run_timeout: got cycles=%0d to=%b want 20 1", cnt, timeout);
    end
    drain_dump(3, 0, 1'b0);
    n_vec++;
    if (timeout !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_sticky: got %b want 1", timeout);
    end
    start_seq();
    #1;
    n_vec++;
    if (timeout !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_clear: got to=%b rdy=%b want 0 1", timeout, in_ready);
    end
  endtask

  // continues from the LOAD state left by test_timeout
  task automatic test_ignore_start();
    load4(32'h55667788);
    start = 1'b1; core_done = 1'b1;
    @(negedge clk); start = 1'b0; core_done = 1'b0;
    #1;
    n_vec++;
    if (core_reset !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL run_first_cycle: got cr=%b busy=%b to=%b want 0 1 0", core_reset, busy, timeout);
    end
    core_done = 1'b1;
    @(negedge clk); core_done = 1'b0;
    drain_dump(3, 0, 1'b1);
  endtask

  task automatic test_done_at_timeout();
    start_seq();
    load4(32'h99AABBCC);
    repeat (19) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk); core_done = 1'b0;
    #1;
    n_vec++;
    if (timeout !== 1'b0 || core_reset !== 1'b1) begin
      n_err++;
      $display("FAIL done_wins: got to=%b cr=%b want 0 1", timeout, core_reset);
    end
    drain_dump(3, 0, 1'b0);
  endtask

  task automatic test_reset_midload();
    start_seq();
    in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk); in_data = 8'h22;
    @(negedge clk); in_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({core_reset, host_owns, in_ready, busy, dm_wen, out_valid} !== 6'b110000) begin
      n_err++;
      $display("FAIL async_abort: got cr/ho/rdy/busy/wen/ov=%b want 110000",
               {core_reset, host_owns, in_ready, busy, dm_wen, out_valid});
    end
    @(negedge clk); reset = 1'b0;
    start_seq();
    in_valid = 1'b1; in_data = 8'h99;
    #1;
    n_vec++;
    if (dm_wen !== 1'b1 || dm_addr !== 8'h00 || dm_wdat !== 8'h99) begin
      n_err++;
      $display("FAIL reload_addr0: got wen=%b a=%h d=%h want 1 00 99", dm_wen, dm_addr, dm_wdat);
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_run_done();
    test_stall();
    test_timeout();
    test_ignore_start();
    test_done_at_timeout();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
